status_led_arbiter: RTL and testbench
=====================================

// Module: status_led_arbiter
// PURPOSE
//  Shares the single status indicator LED between NUM_REQ requesters (armed,
//  triggered, countdown, fault ...) and produces the 2-bit LED status code
//  that feeds the status LED blink FSM.
//  - Fixed-priority arbitration, lowest index wins.
//  - Minimum hold time in 1 Hz ticks, so the LED does not flicker between owners.
//  - One-shot alert override forces solid-on for a fixed number of seconds.
// PARAMETERS
//  NUM_REQ       4           number of requesters (2..8)
//  TICK_DIV      25_000_000  clock cycles per 1 Hz tick (25 MHz clock)
//  HOLD_SECONDS  2           minimum ticks a grant is held before preemption
//  PULSE_SECONDS 3           ticks the alert override holds LED solid-on
// PORTS
//  clock_25mhz  in   1           system clock, all logic on rising edge
//  reset_n      in   1           asynchronous, active-low reset
//  req_mode     in   2*NUM_REQ   per requester i, bits [2i+1:2i]: 00 off, 01 on, 11 blink, 10 = off
//  alert_pulse  in   1           one-cycle strobe: start or restart the alert override
//  led_status   out  2           code to LED FSM: 00 off, 01 solid, 11 blink
//  grant_valid  out  1           a requester currently owns the LED
//  grant_id     out  clog2(NUM_REQ)  index of the owning requester
//  one_hz_tick  out  1           one-cycle tick, exported for the LED blink FSM
// BEHAVIOUR
//  Reset (async, reset_n=0)
//   - state=S_IDLE; led_status=00; grant_valid=0; grant_id=0.
//   - Prescaler, hold_cnt and pulse_cnt cleared.
//   - Takes effect immediately, mid-operation included. No output glitch after release.
//  Prescaler
//   - Free-running 0..TICK_DIV-1; one_hz_tick=1 on the cycle count==TICK_DIV-1.
//   - Never reset by grants or alerts, so the first hold period lasts HOLD_SECONDS-1 to HOLD_SECONDS s.
//  Active requester: req_mode[i] is 01 or 11.
//  Winner: the lowest-index active requester.
//  Registered outputs: all change on the same edge as state. Request -> led_status latency is 1 cycle.
//  S_IDLE
//   - Outputs 00 / grant_valid=0.
//   - Any active requester -> S_GRANT, grant_id=winner, hold_cnt=0.
//  S_GRANT
//   - led_status follows req_mode[grant_id] live each cycle, 1-cycle registered.
//   - hold_cnt increments on tick and saturates at HOLD_SECONDS.
//   - Owner goes inactive -> re-arbitrate next edge, hold ignored: new winner (hold_cnt=0) or S_IDLE.
//   - hold_cnt==HOLD_SECONDS and winner != grant_id -> switch to winner, hold_cnt=0.
//   - Otherwise stay; a higher-priority request waits for hold expiry.
//  S_ALERT
//   - led_status=01; grant_valid=0.
//   - pulse_cnt increments on tick.
//   - When pulse_cnt==PULSE_SECONDS: winner -> S_GRANT (hold_cnt=0), else S_IDLE.
//  Alert rules
//   - alert_pulse in any state -> S_ALERT next edge, pulse_cnt=0.
//   - alert_pulse in S_ALERT restarts the count.
//  Simultaneous events
//   - alert beats tick and grant changes; a tick coincident with the alert is not counted.
//   - Owner drop beats hold expiry; both re-arbitrate identically.
//  Width rules
//   - hold_cnt/pulse_cnt are clog2(max+1) bits, saturating, no wrap.
//   - Prescaler is clog2(TICK_DIV) bits.
//  Illegal code 10: never reaches led_status; the owner is treated as inactive.
// STRUCTURE
//  - Package status_led_pkg: LED_OFF=2'b00, LED_ON=2'b01, LED_BLINK=2'b11;
//    state encodings S_IDLE/S_GRANT/S_ALERT; is_active() helper.
//  - Sub-module tick_prescaler(clock_25mhz, reset_n, tick), parameter TICK_DIV. Reused by the blink FSM.
//  - Arbiter: one combinational priority encoder plus one registered FSM.
// TESTING (bench uses TICK_DIV=10, HOLD_SECONDS=2, PULSE_SECONDS=3)
//  - Reset: hold reset_n=0 mid-grant -> led_status=00, grant_valid=0 the same cycle; stays idle after release with req_mode=0.
//  - Single request: req_mode[3:2]=11 -> next edge grant_id=1, led_status=11. Drop to 00 -> next edge led_status=00, S_IDLE.
//  - Hold/preempt: req 1 owns the LED; req 0=01 raised at once -> led_status stays 11 until hold_cnt=2 ticks, then grant_id=0, led_status=01.
//  - Alert: alert_pulse during a grant -> led_status=01 for 3 ticks. Second pulse mid-alert extends it. Resumes to winner, hold_cnt=0.
//  - Coincidence: alert_pulse on the tick cycle -> tick not counted, exactly 3 further ticks in S_ALERT.
//  - Illegal 10 on the owner -> immediate re-arbitration; led_status never 10. Random req_mode soak checks the same.

Source files
------------

// File: rtl/status_led_pkg.sv
// Shared encodings for the status LED path: LED codes, arbiter states and the
// requester-activity helper used by both the arbiter and the blink FSM.
package status_led_pkg;

  localparam logic [1:0] LED_OFF   = 2'b00;
  localparam logic [1:0] LED_ON    = 2'b01;
  localparam logic [1:0] LED_BLINK = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_ALERT = 2'd2
  } arb_state_e;

  // Code 2'b10 is illegal and counts as "not requesting".
  function automatic logic is_active(input logic [1:0] mode);
    return (mode == LED_ON) || (mode == LED_BLINK);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle tick every TICK_DIV clocks.
// Only reset_n clears it; consumers never restart it.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 25_000_000
) (
  input  logic clock_25mhz,
  input  logic reset_n,
  output logic tick
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = (count_q == CNT_LAST) ? '0 : count_q + CNT_W'(1);
  end

  always_ff @(posedge clock_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tick = (count_q == CNT_LAST);

endmodule

// File: rtl/status_led_arbiter.sv
// Fixed-priority owner selection for the shared status LED, with a minimum
// hold time between owners and a one-shot solid-on alert override.
module status_led_arbiter
  import status_led_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned TICK_DIV      = 25_000_000,
  parameter int unsigned HOLD_SECONDS  = 2,
  parameter int unsigned PULSE_SECONDS = 3,
  localparam int unsigned ID_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                   clock_25mhz,
  input  logic                   reset_n,
  input  logic [2*NUM_REQ-1:0]   req_mode,
  input  logic                   alert_pulse,
  output logic [1:0]             led_status,
  output logic                   grant_valid,
  output logic [ID_W-1:0]        grant_id,
  output logic                   one_hz_tick
);

  localparam int unsigned HOLD_W  = (HOLD_SECONDS > 0) ? $clog2(HOLD_SECONDS + 1) : 1;
  localparam int unsigned PULSE_W = (PULSE_SECONDS > 0) ? $clog2(PULSE_SECONDS + 1) : 1;
  localparam logic [HOLD_W-1:0]  HOLD_MAX  = HOLD_W'(HOLD_SECONDS);
  localparam logic [PULSE_W-1:0] PULSE_MAX = PULSE_W'(PULSE_SECONDS);

  arb_state_e         state_q, state_d;
  logic [ID_W-1:0]    grant_q, grant_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [PULSE_W-1:0] pulse_q, pulse_d;
  logic [1:0]         led_q, led_d;
  logic               valid_q, valid_d;

  logic               tick;
  logic               win_found;
  logic [ID_W-1:0]    win_id;
  logic               owner_active;

  function automatic logic [1:0] mode_of(input logic [2*NUM_REQ-1:0] modes,
                                         input logic [ID_W-1:0]      id);
    logic [1:0] m;
    m = LED_OFF;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (id == ID_W'(i)) m = modes[2*i +: 2];
    end
    return m;
  endfunction

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_prescaler (
    .clock_25mhz (clock_25mhz),
    .reset_n     (reset_n),
    .tick        (tick)
  );

  // Lowest active index wins.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_found && is_active(req_mode[2*i +: 2])) begin
        win_found = 1'b1;
        win_id    = ID_W'(i);
      end
    end
  end

  assign owner_active = is_active(mode_of(req_mode, grant_q));

  always_ff @(posedge clock_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      hold_q  <= '0;
      pulse_q <= '0;
      led_q   <= LED_OFF;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      hold_q  <= hold_d;
      pulse_q <= pulse_d;
      led_q   <= led_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    hold_d  = hold_q;
    pulse_d = pulse_q;
    // Alert outranks ticks and ownership changes; a coincident tick is dropped.
    if (alert_pulse) begin
      state_d = S_ALERT;
      pulse_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (win_found) begin
            state_d = S_GRANT;
            grant_d = win_id;
            hold_d  = '0;
          end
        end
        S_GRANT: begin
          if (!owner_active || (hold_q == HOLD_MAX && win_id != grant_q)) begin
            if (win_found) begin
              grant_d = win_id;
              hold_d  = '0;
            end else begin
              state_d = S_IDLE;
            end
          end else if (tick && hold_q != HOLD_MAX) begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
        S_ALERT: begin
          if (pulse_q == PULSE_MAX) begin
            if (win_found) begin
              state_d = S_GRANT;
              grant_d = win_id;
              hold_d  = '0;
            end else begin
              state_d = S_IDLE;
            end
          end else if (tick) begin
            pulse_d = pulse_q + PULSE_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs are derived from the next state so they register on the same edge.
  always_comb begin
    led_d   = LED_OFF;
    valid_d = 1'b0;
    case (state_d)
      S_GRANT: begin
        led_d   = mode_of(req_mode, grant_d);
        valid_d = 1'b1;
      end
      S_ALERT: led_d = LED_ON;
      default: begin
        led_d   = LED_OFF;
        valid_d = 1'b0;
      end
    endcase
  end

  assign led_status  = led_q;
  assign grant_valid = valid_q;
  assign grant_id    = grant_q;
  assign one_hz_tick = tick;

endmodule

// File: tb/tb_status_led_arbiter.sv
// Randomised and directed bench for status_led_arbiter: a behavioural model
// queues expected outputs per edge, a separate monitor compares them.
module tb_status_led_arbiter;

  localparam int NR = 4;
  localparam int TD = 10;
  localparam int HS = 2;
  localparam int PS = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [2*NR-1:0] req = '0;
  logic            alert = 1'b0;
  logic [1:0]      led;
  logic            gv;
  logic [1:0]      gid;
  logic            tick;

  status_led_arbiter #(
    .NUM_REQ       (NR),
    .TICK_DIV      (TD),
    .HOLD_SECONDS  (HS),
    .PULSE_SECONDS (PS)
  ) dut (
    .clock_25mhz (clk),
    .reset_n     (rst_n),
    .req_mode    (req),
    .alert_pulse (alert),
    .led_status  (led),
    .grant_valid (gv),
    .grant_id    (gid),
    .one_hz_tick (tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    int led;
    int valid;
    int id;
    int tick;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Model: mode 0 = nobody owns, 1 = owned, 2 = alert showing.
  int m_mode, m_owner, m_held, m_alert_secs, m_phase;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int req_code(input logic [2*NR-1:0] r, input int i);
    return int'(r[2*i +: 2]);
  endfunction

  function automatic bit wants(input logic [2*NR-1:0] r, input int i);
    int c;
    c = req_code(r, i);
    return (c == 1) || (c == 3);
  endfunction

  function automatic int first_wanting(input logic [2*NR-1:0] r);
    for (int i = 0; i < NR; i++) begin
      if (wants(r, i)) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_owner = 0; m_held = 0; m_alert_secs = 0; m_phase = 0;
  endtask

  task automatic model_step(input logic [2*NR-1:0] r, input bit a);
    bit   second;
    int   w;
    exp_t e;
    second  = (m_phase == TD - 1);
    w       = first_wanting(r);
    m_phase = (m_phase + 1) % TD;
    if (a) begin
      m_mode = 2;
      m_alert_secs = 0;
    end else if (m_mode == 0) begin
      if (w >= 0) begin m_mode = 1; m_owner = w; m_held = 0; end
    end else if (m_mode == 1) begin
      if (!wants(r, m_owner) || (m_held >= HS && w != m_owner)) begin
        if (w >= 0) begin m_owner = w; m_held = 0; end
        else m_mode = 0;
      end else if (second && m_held < HS) begin
        m_held++;
      end
    end else begin
      if (m_alert_secs >= PS) begin
        if (w >= 0) begin m_mode = 1; m_owner = w; m_held = 0; end
        else m_mode = 0;
      end else if (second) begin
        m_alert_secs++;
      end
    end
    e.led   = (m_mode == 2) ? 1 : (m_mode == 1) ? req_code(r, m_owner) : 0;
    e.valid = (m_mode == 1) ? 1 : 0;
    e.id    = m_owner;
    e.tick  = (m_phase == TD - 1) ? 1 : 0;
    sb.push_back(e);
  endtask

  task automatic drive(input logic [2*NR-1:0] r, input bit a);
    req   = r;
    alert = a;
    @(posedge clk);
    model_step(r, a);
    #2;
  endtask

  task automatic hold_for(input logic [2*NR-1:0] r, input int n);
    for (int k = 0; k < n; k++) drive(r, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    req   = '0;
    alert = 1'b0;
    #1;
    check("reset_led", int'(led), 0);
    check("reset_valid", int'(gv), 0);
    check("reset_id", int'(gid), 0);
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check("led_status", int'(led), e.led);
        check("grant_valid", int'(gv), e.valid);
        if (e.valid != 0) check("grant_id", int'(gid), e.id);
        check("one_hz_tick", int'(tick), e.tick);
        check("led_never_10", (led == 2'b10) ? 1 : 0, 0);
      end
    end
  end

  initial begin : stimulus
    logic [2*NR-1:0] r;
    do_reset();
    hold_for('0, 3);

    // Single requester, then drop.
    hold_for(8'h0C, 6);
    hold_for('0, 3);

    // Requester 1 owns; requester 0 waits out the hold time.
    hold_for(8'h0C, 3);
    hold_for(8'h0D, 35);

    // Alert, extended by a second pulse, then resume.
    drive(8'h0D, 1'b1);
    hold_for(8'h0D, 15);
    drive(8'h0D, 1'b1);
    hold_for(8'h0D, 45);

    // Alert landing on the tick cycle.
    for (int k = 0; k < TD && m_phase != TD - 1; k++) drive(8'h0C, 1'b0);
    drive(8'h0C, 1'b1);
    hold_for(8'h0C, 45);

    // Illegal code on the owner.
    hold_for(8'h0C, 5);
    hold_for(8'h08, 3);
    hold_for(8'hC8, 4);
    hold_for(8'h8C, 4);
    hold_for(8'h0C, 5);

    // Reset mid-grant, then idle.
    do_reset();
    hold_for('0, 5);

    // Random soak with occasionally changing requests and rare alerts.
    r = '0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(7) == 0) r = 8'($urandom);
      drive(r, ($urandom_range(99) == 0));
    end
    hold_for('0, 2);

    @(negedge clk);
    #1;
    if (sb.size() != 0) check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
